// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD window controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    CmdLoad    = 3'd0,
    CmdZoomIn  = 3'd1,
    CmdZoomFit = 3'd2,
    CmdRight   = 3'd3,
    CmdLeft    = 3'd4,
    CmdUp      = 3'd5,
    CmdDown    = 3'd6,
    CmdMirror  = 3'd7
  } cmd_e;

  typedef enum logic {
    ModeFit,
    ModeZoom
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoadData,
    StOutput
  } state_e;

  // $clog2 that never yields a zero-width vector
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lcd_img_mem.sv
// Image store: one synchronous write port, one asynchronous read port, no reset.
module lcd_img_mem #(
  parameter int unsigned Depth = 108,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [Depth];

  // Pixel capture during LOAD
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_window_ctrl.sv
// LCD window controller: serial image load, then WIN x WIN windows in fit or zoom mode.
// Optional horizontal mirror enabled by defining LCD_MIRROR_EN.
module lcd_window_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned WIN   = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [2:0]    cmd_i,
  input  logic          cmd_valid_i,
  input  logic [DW-1:0] datain_i,
  output logic [DW-1:0] dataout_o,
  output logic          output_valid_o,
  output logic          busy_o
);

  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned AW    = clog2_min1(NPix);
  localparam int unsigned CW    = clog2_min1(WIN);
  localparam int unsigned XW    = clog2_min1(IMG_W);
  localparam int unsigned YW    = clog2_min1(IMG_H);
  localparam int unsigned StepX = IMG_W / WIN;
  localparam int unsigned StepY = IMG_H / WIN;

  localparam logic [XW-1:0] OxCtr    = XW'(IMG_W / 2 - WIN / 2);
  localparam logic [YW-1:0] OyCtr    = YW'((IMG_H + 1) / 2 - WIN / 2);
  localparam logic [XW-1:0] OxMax    = XW'(IMG_W - WIN);
  localparam logic [YW-1:0] OyMax    = YW'(IMG_H - WIN);
  localparam logic [AW-1:0] LastAddr = AW'(NPix - 1);
  localparam logic [CW-1:0] LastIdx  = CW'(WIN - 1);

  state_e        state_q;
  mode_e         mode_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic [CW-1:0] row_q, col_q;
  logic [AW-1:0] waddr_q;
  logic          busy_q, ovalid_q;
  logic [DW-1:0] dout_q;
`ifdef LCD_MIRROR_EN
  logic          mirror_q;
`endif

  logic [CW-1:0] col_eff;
  logic [31:0]   pix_row, pix_col;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  // Window pixel address for the current row/col counters
  always_comb begin
    col_eff = col_q;
`ifdef LCD_MIRROR_EN
    if (mirror_q) col_eff = LastIdx - col_q;
`endif
    if (mode_q == ModeFit) begin
      pix_row = StepY / 2 + 32'(row_q) * StepY;
      pix_col = StepX / 2 + 32'(col_eff) * StepX;
    end else begin
      pix_row = 32'(oy_q) + 32'(row_q);
      pix_col = 32'(ox_q) + 32'(col_eff);
    end
    raddr = AW'(pix_row * IMG_W + pix_col);
  end

  lcd_img_mem #(
    .Depth(NPix),
    .DW   (DW),
    .AW   (AW)
  ) u_img_mem (
    .clk_i  (clk_i),
    .we_i   (state_q == StLoadData),
    .waddr_i(waddr_q),
    .wdata_i(datain_i),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  // Command FSM with registered outputs, origin/mode state and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mode_q   <= ModeFit;
      ox_q     <= OxCtr;
      oy_q     <= OyCtr;
      row_q    <= '0;
      col_q    <= '0;
      waddr_q  <= '0;
      busy_q   <= 1'b0;
      ovalid_q <= 1'b0;
      dout_q   <= '0;
`ifdef LCD_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // busy_q still high here means the last output cycle just ended
          ovalid_q <= 1'b0;
          busy_q   <= 1'b0;
          row_q    <= '0;
          col_q    <= '0;
          if (cmd_valid_i && !busy_q) begin
            busy_q  <= 1'b1;
            state_q <= StOutput;
            case (cmd_e'(cmd_i))
              CmdLoad: begin
                state_q <= StLoadData;
                waddr_q <= '0;
              end
              CmdZoomIn: begin
                if (mode_q == ModeFit) begin
                  mode_q <= ModeZoom;
                  ox_q   <= OxCtr;
                  oy_q   <= OyCtr;
                end
              end
              CmdZoomFit: begin
                mode_q <= ModeFit;
                ox_q   <= OxCtr;
                oy_q   <= OyCtr;
              end
              CmdRight: if (mode_q == ModeZoom && ox_q < OxMax) ox_q <= ox_q + 1'b1;
              CmdLeft:  if (mode_q == ModeZoom && ox_q != '0)   ox_q <= ox_q - 1'b1;
              CmdUp:    if (mode_q == ModeZoom && oy_q != '0)   oy_q <= oy_q - 1'b1;
              CmdDown:  if (mode_q == ModeZoom && oy_q < OyMax) oy_q <= oy_q + 1'b1;
              CmdMirror: begin
`ifdef LCD_MIRROR_EN
                mirror_q <= ~mirror_q;
`endif
              end
              default: ;
            endcase
          end
        end
        StLoadData: begin
          waddr_q <= waddr_q + 1'b1;
          if (waddr_q == LastAddr) begin
            state_q <= StOutput;
            mode_q  <= ModeFit;
            ox_q    <= OxCtr;
            oy_q    <= OyCtr;
`ifdef LCD_MIRROR_EN
            mirror_q <= 1'b0;
`endif
          end
        end
        StOutput: begin
          ovalid_q <= 1'b1;
          dout_q   <= rdata;
          col_q    <= col_q + 1'b1;
          if (col_q == LastIdx) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
            if (row_q == LastIdx) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dataout_o      = dout_q;
  assign output_valid_o = ovalid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_lcd_window_ctrl.sv
// Scoreboard bench for lcd_window_ctrl (default 12x9 image, 4x4 window, 8-bit pixels).
module tb_lcd_window_ctrl;

  localparam logic [2:0] CLoad    = 3'd0;
  localparam logic [2:0] CZoomIn  = 3'd1;
  localparam logic [2:0] CZoomFit = 3'd2;
  localparam logic [2:0] CRight   = 3'd3;
  localparam logic [2:0] CLeft    = 3'd4;
  localparam logic [2:0] CUp      = 3'd5;
  localparam logic [2:0] CDown    = 3'd6;
  localparam logic [2:0] CMirror  = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int exp_q[$];
  int checks = 0;
  int fails  = 0;
  int mon_exp;

  int fit_v[16]  = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
  int zoom_v[16] = '{40, 41, 42, 43, 52, 53, 54, 55, 64, 65, 66, 67, 76, 77, 78, 79};
  // Fit window after the first 50 pixels were reloaded with 100+i
  int part_v[16] = '{113, 116, 119, 122, 137, 140, 143, 146, 61, 64, 67, 70, 85, 88, 91, 94};

  always #5 clk = ~clk;

  lcd_window_ctrl #(
    .IMG_W(12),
    .IMG_H(9),
    .WIN  (4),
    .DW   (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_i         (cmd),
    .cmd_valid_i   (cmd_valid),
    .datain_i      (datain),
    .dataout_o     (dataout),
    .output_valid_o(output_valid),
    .busy_o        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_vec(input int v[16]);
    for (int i = 0; i < 16; i++) exp_q.push_back(v[i]);
  endfunction

  function automatic void push_zoom(input int ox, input int oy, input bit mir);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back((oy + r) * 12 + ox + (mir ? 3 - c : c));
  endfunction

  // Monitor: pop and compare on every valid output cycle
  always @(negedge clk) begin
    if (rst_n && output_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got %0d, required no output (t=%0t)", dataout, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("window_pixel", {24'd0, dataout}, mon_exp);
      end
    end
  end

  task automatic do_cmd(input logic [2:0] c);
    @(posedge clk); #1;
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    if (c != CLoad) begin
      check("valid_low_accept_cycle", output_valid, 0);
      @(posedge clk); #1;
      check("valid_one_after_accept", output_valid, 1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_released", busy, 0);
    check("all_outputs_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_image();
    push_vec(fit_v);
    do_cmd(CLoad);
    for (int i = 0; i < 108; i++) begin
      datain = 8'(i);
      @(posedge clk); #1;
      if (i < 107) begin
        if (busy !== 1'b1) check("busy_during_load", busy, 1);
      end
    end
    check("busy_at_load_end", busy, 1);
    check("valid_low_at_load_end", output_valid, 0);
    @(posedge clk); #1;
    check("valid_after_last_capture", output_valid, 1);
    wait_idle(40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd       = 3'd0;
    cmd_valid = 1'b0;
    datain    = 8'd0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_valid", output_valid, 0);
    check("reset_dataout", dataout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    load_image();

    push_vec(zoom_v);
    do_cmd(CZoomIn);
    wait_idle(40);

    for (int k = 1; k <= 5; k++) begin
      push_zoom((k < 4) ? 4 + k : 8, 3, 1'b0);
      do_cmd(CRight);
      wait_idle(40);
    end

    // Already zoomed: origin stays at the clamped position
    push_zoom(8, 3, 1'b0);
    do_cmd(CZoomIn);
    wait_idle(40);

    push_vec(fit_v);
    do_cmd(CZoomFit);
    wait_idle(40);

    push_vec(zoom_v);
    do_cmd(CZoomIn);
    wait_idle(40);

    for (int k = 1; k <= 5; k++) begin
      push_zoom(4, (k < 3) ? 3 - k : 0, 1'b0);
      do_cmd(CUp);
      wait_idle(40);
    end

    for (int k = 1; k <= 7; k++) begin
      push_zoom(4, (k < 5) ? k : 5, 1'b0);
      do_cmd(CDown);
      wait_idle(40);
    end

    for (int k = 1; k <= 5; k++) begin
      push_zoom((k < 4) ? 4 - k : 0, 5, 1'b0);
      do_cmd(CLeft);
      wait_idle(40);
    end

    push_vec(fit_v);
    do_cmd(CZoomFit);
    wait_idle(40);

    // LEFT in fit mode, with a command pulse while busy that must be dropped
    push_vec(fit_v);
    do_cmd(CLeft);
    cmd       = CZoomIn;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle(40);

`ifdef LCD_MIRROR_EN
    push_vec(zoom_v);
    do_cmd(CZoomIn);
    wait_idle(40);
    push_zoom(4, 3, 1'b1);
    do_cmd(CMirror);
    wait_idle(40);
    push_zoom(5, 3, 1'b1);
    do_cmd(CRight);
    wait_idle(40);
    push_zoom(5, 3, 1'b0);
    do_cmd(CMirror);
    wait_idle(40);
    push_vec(fit_v);
    do_cmd(CZoomFit);
    wait_idle(40);
`else
    push_vec(fit_v);
    do_cmd(CMirror);
    wait_idle(40);
`endif

    // Abort a LOAD after 50 captures; the partial image must remain
    do_cmd(CLoad);
    for (int i = 0; i < 50; i++) begin
      datain = 8'(100 + i);
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", output_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    push_vec(part_v);
    do_cmd(CRight);
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
